button_debounce: RTL and testbench



---
 rtl/button_debounce_pkg.sv | 20 ++
 rtl/button_debounce_chan.sv | 166 ++++++++++++++++
 rtl/button_debounce.sv | 42 ++++
 tb/tb_button_debounce.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared types and constants for the push-button debounce block.
// Holds the channel state enum, default 50 MHz timings and a width helper.
package button_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_HOLD_CYCLES     = 50000000;
    localparam int DEF_REPEAT_CYCLES   = 12500000;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debounce_chan.sv
// One button channel: 2-flop synchroniser, debounce FSM, pulses, sticky flag.
// Ports: clk, reset_n, button_n (raw, active-low), clr_latched (in);
//        btn_n_out, press_pulse, release_pulse, press_latched, repeat_pulse (out).
// Auto-repeat is built only when BUTTON_DEBOUNCE_REPEAT_EN is defined.
module button_debounce_chan
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_n,
    input  logic clr_latched,
    output logic btn_n_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_latched,
    output logic repeat_pulse
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 ||
        REPEAT_CYCLES > HOLD_CYCLES) begin : g_bad_repeat
        $error("need 1 <= REPEAT_CYCLES <= HOLD_CYCLES");
    end

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic sync_meta;
    logic sync_n;

    // Reset to 1 so leaving reset never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b1;
            sync_n    <= 1'b1;
        end else begin
            sync_meta <= button_n;
            sync_n    <= sync_meta;
        end
    end

    btn_state_e    state;
    btn_state_e    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          press_next;
    logic          release_next;
    logic          level_next;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        unique case (state)
            RELEASED: begin
                if (!sync_n) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync_n) begin
                    state_next = RELEASED;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (sync_n) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!sync_n) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_next   = RELEASED;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
        level_next = !(state_next == PRESSED ||
                       state_next == RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RELEASED;
            cnt           <= '0;
            btn_n_out     <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_latched <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            btn_n_out     <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            // A pulse arriving with a clear keeps the flag set.
            press_latched <= press_pulse |
                             (press_latched & ~clr_latched);
        end
    end

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    // Reload so the next hit of HOLD_LAST is REPEAT_CYCLES later.
    localparam logic [HW-1:0] HOLD_RELOAD =
        HW'(HOLD_CYCLES - REPEAT_CYCLES);

    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_next;
    logic          repeat_next;

    always_comb begin
        hold_next   = hold_cnt;
        repeat_next = 1'b0;
        if (state_next == RELEASED) begin
            hold_next = '0;
        end else if (state == PRESS_WAIT &&
                     state_next == PRESSED) begin
            hold_next = '0;
        end else if (state == PRESSED ||
                     state == RELEASE_WAIT) begin
            if (hold_cnt == HOLD_LAST) begin
                hold_next   = HOLD_RELOAD;
                repeat_next = 1'b1;
            end else begin
                hold_next = hold_cnt + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt     <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            hold_cnt     <= hold_next;
            repeat_pulse <= repeat_next;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Debounce/edge-detect stage between the button pads and the SOPC button PIO.
// Ports: clk, reset_n, button_n[N], clr_latched[N] (in); btn_n_out,
//        press_pulse, release_pulse, press_latched, repeat_pulse [N] (out).
// Optional auto-repeat: define BUTTON_DEBOUNCE_REPEAT_EN.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] button_n,
    output logic [NUM_BUTTONS-1:0] btn_n_out,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] press_latched,
    input  logic [NUM_BUTTONS-1:0] clr_latched,
    output logic [NUM_BUTTONS-1:0] repeat_pulse
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        button_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .button_n      (button_n[i]),
            .clr_latched   (clr_latched[i]),
            .btn_n_out     (btn_n_out[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .press_latched (press_latched[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with short debounce/hold timings.
// Pulse events are scoreboarded by cycle; levels and flags checked inline.
module tb_button_debounce;

    localparam int NB  = 4;
    localparam int DB  = 16;
    localparam int HC  = 32;
    localparam int RC  = 8;
    localparam int LAT = DB + 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NB-1:0] button_n = 4'hF;
    logic [NB-1:0] clr_latched = 4'h0;
    logic [NB-1:0] btn_n_out;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] release_pulse;
    logic [NB-1:0] press_latched;
    logic [NB-1:0] repeat_pulse;

    button_debounce #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HC),
        .REPEAT_CYCLES   (RC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .button_n      (button_n),
        .btn_n_out     (btn_n_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_latched (press_latched),
        .clr_latched   (clr_latched),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rep;
    } ev_t;

    ev_t sbq[$];

    function automatic void expect_ev(input int c, input logic [3:0] p,
                                      input logic [3:0] r,
                                      input logic [3:0] q);
        ev_t e;
        e.cyc = c;
        e.press = p;
        e.rel = r;
        e.rep = q;
        sbq.push_back(e);
    endfunction

    // Any pulse activity must match the next scheduled event exactly.
    always @(negedge clk) begin
        if (reset_n &&
            (press_pulse | release_pulse | repeat_pulse) != 4'h0) begin
            compared++;
            if (sbq.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_event: cyc=%0d p=%h r=%h q=%h",
                         cyc, press_pulse, release_pulse, repeat_pulse);
            end else begin
                ev_t e;
                e = sbq.pop_front();
                if (e.cyc !== cyc || e.press !== press_pulse ||
                    e.rel !== release_pulse || e.rep !== repeat_pulse) begin
                    mismatched++;
                    $display({"FAIL event: got cyc=%0d p=%h r=%h q=%h",
                              " expected cyc=%0d p=%h r=%h q=%h"},
                             cyc, press_pulse, release_pulse, repeat_pulse,
                             e.cyc, e.press, e.rel, e.rep);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        button_n = 4'hF;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        compared++;
        if ({btn_n_out, press_pulse, release_pulse, press_latched,
             repeat_pulse} !== 20'hF0000) begin
            mismatched++;
            $display("FAIL reset_idle: got %h/%h/%h/%h/%h expected F/0/0/0/0",
                     btn_n_out, press_pulse, release_pulse,
                     press_latched, repeat_pulse);
        end
        button_n = 4'hE;
        expect_ev(cyc + LAT, 4'h1, 4'h0, 4'h0);
        tick(LAT + 3);
        compared++;
        if (btn_n_out !== 4'hE || press_latched !== 4'h1) begin
            mismatched++;
            $display("FAIL pre_reset_pressed: got %h/%h expected E/1",
                     btn_n_out, press_latched);
        end
        #2 reset_n = 1'b0;
        #1;
        compared++;
        if ({btn_n_out, press_pulse, release_pulse, press_latched,
             repeat_pulse} !== 20'hF0000) begin
            mismatched++;
            $display("FAIL reset_mid_press: got %h/%h/%h/%h/%h expected F/0/0/0/0",
                     btn_n_out, press_pulse, release_pulse,
                     press_latched, repeat_pulse);
        end
        tick(3);
        reset_n = 1'b1;
        expect_ev(cyc + LAT, 4'h1, 4'h0, 4'h0);
        tick(LAT - 1);
        compared++;
        if (btn_n_out !== 4'hF) begin
            mismatched++;
            $display("FAIL reset_exit_wait: got %h expected F", btn_n_out);
        end
        tick(1);
        compared++;
        if (btn_n_out !== 4'hE || press_pulse !== 4'h1) begin
            mismatched++;
            $display("FAIL reset_exit_press: got %h/%h expected E/1",
                     btn_n_out, press_pulse);
        end
        tick(2);
        button_n = 4'hF;
        expect_ev(cyc + LAT, 4'h0, 4'h1, 4'h0);
        tick(LAT + 2);
        compared++;
        if (btn_n_out !== 4'hF || sbq.size() != 0) begin
            mismatched++;
            $display("FAIL reset_release: got %h pend=%0d expected F pend=0",
                     btn_n_out, sbq.size());
        end
    endtask

    task automatic test_clean_press;
        clr_latched = 4'h1;
        tick(1);
        clr_latched = 4'h0;
        tick(1);
        compared++;
        if (press_latched !== 4'h0) begin
            mismatched++;
            $display("FAIL clean_pre_clear: got %h expected 0", press_latched);
        end
        button_n = 4'hE;
        expect_ev(cyc + LAT, 4'h1, 4'h0, 4'h0);
        tick(LAT - 1);
        compared++;
        if (btn_n_out !== 4'hF || press_pulse !== 4'h0) begin
            mismatched++;
            $display("FAIL clean_before: got %h/%h expected F/0",
                     btn_n_out, press_pulse);
        end
        tick(1);
        compared++;
        if (btn_n_out !== 4'hE || press_pulse !== 4'h1) begin
            mismatched++;
            $display("FAIL clean_edge: got %h/%h expected E/1",
                     btn_n_out, press_pulse);
        end
        tick(1);
        compared++;
        if (press_pulse !== 4'h0 || press_latched !== 4'h1) begin
            mismatched++;
            $display("FAIL clean_one_cycle: got %h/%h expected 0/1",
                     press_pulse, press_latched);
        end
        button_n = 4'hF;
        expect_ev(cyc + LAT, 4'h0, 4'h1, 4'h0);
        tick(LAT + 2);
        compared++;
        if (btn_n_out !== 4'hF || sbq.size() != 0) begin
            mismatched++;
            $display("FAIL clean_release: got %h pend=%0d expected F pend=0",
                     btn_n_out, sbq.size());
        end
    endtask

    task automatic test_bounce;
        bit early;
        button_n = 4'hD;
        tick(10);
        button_n = 4'hF;
        tick(3);
        button_n = 4'hD;
        expect_ev(cyc + LAT, 4'h2, 4'h0, 4'h0);
        early = 1'b0;
        repeat (LAT - 1) begin
            tick(1);
            if (btn_n_out[1] !== 1'b1) early = 1'b1;
        end
        compared++;
        if (early) begin
            mismatched++;
            $display("FAIL bounce_early: level went low early, expected stay 1");
        end
        tick(1);
        compared++;
        if (btn_n_out !== 4'hD) begin
            mismatched++;
            $display("FAIL bounce_accept: got %h expected D", btn_n_out);
        end
        tick(2);
        button_n = 4'hF;
        expect_ev(cyc + LAT, 4'h0, 4'h2, 4'h0);
        tick(LAT + 2);
        compared++;
        if (btn_n_out !== 4'hF || sbq.size() != 0) begin
            mismatched++;
            $display("FAIL bounce_release: got %h pend=%0d expected F pend=0",
                     btn_n_out, sbq.size());
        end
    endtask

    task automatic test_glitch;
        bit low_seen;
        low_seen = 1'b0;
        button_n = 4'hB;
        repeat (15) begin
            tick(1);
            if (btn_n_out !== 4'hF) low_seen = 1'b1;
        end
        button_n = 4'hF;
        repeat (30) begin
            tick(1);
            if (btn_n_out !== 4'hF) low_seen = 1'b1;
        end
        compared++;
        if (low_seen || press_latched[2] !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch: low_seen=%0b latched=%h expected 0/bit2=0",
                     low_seen, press_latched);
        end
    endtask

    task automatic test_simultaneous;
        button_n = 4'h5;
        expect_ev(cyc + LAT, 4'hA, 4'h0, 4'h0);
        tick(40);
        compared++;
        if (btn_n_out !== 4'h5) begin
            mismatched++;
            $display("FAIL simul_level: got %h expected 5", btn_n_out);
        end
        button_n = 4'hF;
        expect_ev(cyc + LAT, 4'h0, 4'hA, 4'h0);
        tick(LAT + 2);
        compared++;
        if (btn_n_out !== 4'hF || sbq.size() != 0) begin
            mismatched++;
            $display("FAIL simul_release: got %h pend=%0d expected F pend=0",
                     btn_n_out, sbq.size());
        end
    endtask

    task automatic test_latch;
        compared++;
        if (press_latched !== 4'hB) begin
            mismatched++;
            $display("FAIL latch_initial: got %h expected B", press_latched);
        end
        button_n = 4'hE;
        expect_ev(cyc + LAT, 4'h1, 4'h0, 4'h0);
        tick(LAT);
        clr_latched = 4'h1;
        tick(1);
        clr_latched = 4'h0;
        compared++;
        if (press_latched !== 4'hB) begin
            mismatched++;
            $display("FAIL latch_set_wins: got %h expected B", press_latched);
        end
        clr_latched = 4'h1;
        tick(1);
        clr_latched = 4'h0;
        compared++;
        if (press_latched !== 4'hA) begin
            mismatched++;
            $display("FAIL latch_clear: got %h expected A", press_latched);
        end
        clr_latched = 4'h1;
        tick(1);
        clr_latched = 4'h0;
        compared++;
        if (press_latched !== 4'hA) begin
            mismatched++;
            $display("FAIL latch_clear_noop: got %h expected A", press_latched);
        end
        button_n = 4'hF;
        expect_ev(cyc + LAT, 4'h0, 4'h1, 4'h0);
        tick(LAT + 2);
        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL latch_drain: got pend=%0d expected 0", sbq.size());
        end
    endtask

    task automatic test_repeat;
        int  p;
        bit  rep_seen;
        rep_seen = 1'b0;
        button_n = 4'hE;
        p = cyc + LAT;
        expect_ev(p, 4'h1, 4'h0, 4'h0);
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        expect_ev(p + HC, 4'h0, 4'h0, 4'h1);
        expect_ev(p + HC + RC, 4'h0, 4'h0, 4'h1);
        expect_ev(p + HC + 2 * RC, 4'h0, 4'h0, 4'h1);
`endif
        repeat (LAT + 35) begin
            tick(1);
            if (repeat_pulse !== 4'h0) rep_seen = 1'b1;
        end
        compared++;
        if (press_latched !== 4'hB) begin
            mismatched++;
            $display("FAIL repeat_latch: got %h expected B", press_latched);
        end
        button_n = 4'hF;
        expect_ev(cyc + LAT, 4'h0, 4'h1, 4'h0);
        repeat (LAT + 12) begin
            tick(1);
            if (repeat_pulse !== 4'h0) rep_seen = 1'b1;
        end
        compared++;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        if (rep_seen !== 1'b1 || sbq.size() != 0) begin
            mismatched++;
            $display("FAIL repeat: got seen=%0b pend=%0d expected 1/0",
                     rep_seen, sbq.size());
        end
`else
        if (rep_seen !== 1'b0 || sbq.size() != 0) begin
            mismatched++;
            $display("FAIL repeat_off: got seen=%0b pend=%0d expected 0/0",
                     rep_seen, sbq.size());
        end
`endif
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_latch();
        test_repeat();
        tick(2);
        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drained: got %0d expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
